// File: rtl/msj_pd_scheduler.sv
`default_nettype none
// ============================================================================
// Module : msj_pd_scheduler
// Brief  : Time-multiplexes one PD controller across NUMBER_OF_MOTORS motors,
//          sweeping every motor once per control period.
// Rev    : 1.0
// ============================================================================
module msj_pd_scheduler #(
  parameter int NUMBER_OF_MOTORS = 8,
  parameter int CTRL_LATENCY     = 2,
  parameter int ACK_TIMEOUT      = 255
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic                                     enable,
  input  logic [31:0]                              update_period,
  input  logic                                     clear_flags,
  output logic                                     sensor_req,
  output logic [3:0]                               sensor_motor,
  input  logic                                     sensor_ack,
  input  logic signed [31:0]                       sensor_position,
  input  logic signed [31:0]                       sensor_velocity,
  output logic [3:0]                               pd_motor_sel,
  output logic signed [31:0]                       pd_position,
  output logic signed [31:0]                       pd_velocity,
  output logic                                     pd_update,
  input  logic signed [31:0]                       pd_duty,
  output logic signed [NUMBER_OF_MOTORS-1:0][31:0] duty,
  output logic                                     busy,
  output logic                                     sweep_done,
  output logic                                     overrun,
  output logic [NUMBER_OF_MOTORS-1:0]              timeout_flags
);

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int LAT_W = (CTRL_LATENCY > 1) ? $clog2(CTRL_LATENCY) : 1;
  localparam logic [3:0]       LAST_IDX = 4'(NUMBER_OF_MOTORS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CTRL_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_UPDATE = 3'd2,
    S_WAIT   = 3'd3,
    S_STORE  = 3'd4
  } state_e;

  state_e                                   state_q, state_d;
  logic [3:0]                               idx_q, idx_d;
  logic [TMO_W-1:0]                         tmo_q, tmo_d;
  logic [LAT_W-1:0]                         lat_q, lat_d;
  logic [31:0]                              cnt_q, cnt_d;
  logic [31:0]                              period_q, period_d;
  logic signed [31:0]                       pos_q, pos_d;
  logic signed [31:0]                       vel_q, vel_d;
  logic signed [NUMBER_OF_MOTORS-1:0][31:0] duty_q, duty_d;
  logic [NUMBER_OF_MOTORS-1:0]              tflags_q, tflags_d;
  logic                                     overrun_q, overrun_d;
  logic                                     done_q, done_d;
  logic                                     req_q, req_d;
  logic                                     upd_q, upd_d;
  logic                                     busy_q, busy_d;
  logic [31:0]                              period_live;
  logic                                     tick;
  logic                                     advance;

  // The period is sampled while the counter sits at 0, so a new value only
  // applies from the next wrap and the first period after reset is complete.
  always_comb begin
    period_live = (update_period < 32'd2) ? 32'd2 : update_period;
    period_d    = (cnt_q == 32'd0) ? period_live : period_q;
    tick        = (cnt_q == period_d - 32'd1);
    cnt_d       = tick ? 32'd0 : cnt_q + 32'd1;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = '0;
    lat_d     = '0;
    pos_d     = pos_q;
    vel_d     = vel_q;
    duty_d    = duty_q;
    tflags_d  = clear_flags ? '0 : tflags_q;
    overrun_d = clear_flags ? 1'b0 : overrun_q;
    done_d    = 1'b0;
    advance   = 1'b0;

    if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick && enable) begin
          idx_d   = 4'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (sensor_ack) begin
          pos_d   = sensor_position;
          vel_d   = sensor_velocity;
          state_d = S_UPDATE;
        end else if (tmo_q == TMO_LAST) begin
          for (int m = 0; m < NUMBER_OF_MOTORS; m++)
            if (idx_q == 4'(m)) tflags_d[m] = 1'b1;
          advance = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_UPDATE: state_d = S_WAIT;
      S_WAIT: begin
        if (lat_q == LAT_LAST) state_d = S_STORE;
        else                   lat_d   = lat_q + LAT_W'(1);
      end
      S_STORE: begin
        for (int m = 0; m < NUMBER_OF_MOTORS; m++)
          if (idx_q == 4'(m)) duty_d[m] = pd_duty;
        advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared by STORE and an ack timeout, which skips the motor's update.
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = S_REQ;
      end
    end

    req_d  = (state_d == S_REQ);
    upd_d  = (state_d == S_UPDATE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      tmo_q     <= '0;
      lat_q     <= '0;
      cnt_q     <= 32'd0;
      period_q  <= 32'd0;
      pos_q     <= '0;
      vel_q     <= '0;
      duty_q    <= '0;
      tflags_q  <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      upd_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      lat_q     <= lat_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      pos_q     <= pos_d;
      vel_q     <= vel_d;
      duty_q    <= duty_d;
      tflags_q  <= tflags_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
      req_q     <= req_d;
      upd_q     <= upd_d;
      busy_q    <= busy_d;
    end
  end

  assign sensor_req    = req_q;
  assign sensor_motor  = idx_q;
  assign pd_motor_sel  = idx_q;
  assign pd_position   = pos_q;
  assign pd_velocity   = vel_q;
  assign pd_update     = upd_q;
  assign duty          = duty_q;
  assign busy          = busy_q;
  assign sweep_done    = done_q;
  assign overrun       = overrun_q;
  assign timeout_flags = tflags_q;

endmodule
`default_nettype wire

// File: tb/tb_msj_pd_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_msj_pd_scheduler
// Brief  : Randomized scoreboard bench for msj_pd_scheduler with a sensor
//          responder, latency-exact controller model and sweep-level model.
// Rev    : 1.0
// ============================================================================
module tb_msj_pd_scheduler;

  localparam int N   = 8;
  localparam int L   = 2;
  localparam int TMO = 255;

  logic                      clock, reset_n, enable, clear_flags;
  logic [31:0]               update_period;
  logic                      sensor_req, sensor_ack, pd_update, busy, sweep_done, overrun;
  logic [3:0]                sensor_motor, pd_motor_sel;
  logic signed [31:0]        sensor_position, sensor_velocity, pd_position, pd_velocity, pd_duty;
  logic signed [N-1:0][31:0] duty;
  logic [N-1:0]              timeout_flags;

  msj_pd_scheduler #(.NUMBER_OF_MOTORS(N), .CTRL_LATENCY(L), .ACK_TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .update_period(update_period),
    .clear_flags(clear_flags), .sensor_req(sensor_req), .sensor_motor(sensor_motor),
    .sensor_ack(sensor_ack), .sensor_position(sensor_position), .sensor_velocity(sensor_velocity),
    .pd_motor_sel(pd_motor_sel), .pd_position(pd_position), .pd_velocity(pd_velocity),
    .pd_update(pd_update), .pd_duty(pd_duty), .duty(duty), .busy(busy),
    .sweep_done(sweep_done), .overrun(overrun), .timeout_flags(timeout_flags)
  );

  typedef struct packed {
    logic [3:0]  motor;
    logic [31:0] pos;
    logic [31:0] vel;
    longint      ack_cyc;
  } upd_t;

  typedef struct packed {
    logic [N-1:0][31:0] d;
    logic [N-1:0]       tf;
    int                 cycles;
  } sweep_t;

  upd_t   upd_q[$];
  sweep_t sweep_q[$];

  // Sweep-level model: expected duty table, sticky flags, busy cycles per sweep.
  logic [N-1:0][31:0] mdl_duty = '0;
  logic [N-1:0]       mdl_tf   = '0;
  int                 mdl_cycles = 0;

  int never_ack_motor = -1;
  int delay_motor     = -1;
  int delay_val       = 0;
  bit rand_delay      = 1'b0;
  bit noise_en        = 1'b0;

  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] pd_fn(input logic [31:0] p, input logic [31:0] v, input logic [3:0] m);
    return (p * 32'd3) - {v[31], v[31:1]} + ({28'd0, m} * 32'd1000);
  endfunction

  task automatic push_sweep();
    sweep_t s;
    s.d      = mdl_duty;
    s.tf     = mdl_tf;
    s.cycles = mdl_cycles;
    sweep_q.push_back(s);
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // Sensor side: decides each motor's ack delay and records the expectations.
  initial begin : responder
    bit   pend, skip;
    int   cur_m, wait_left, d0;
    upd_t e;
    pend = 1'b0; skip = 1'b0; cur_m = 0; wait_left = 0; d0 = 0;
    sensor_ack = 1'b0; sensor_position = '0; sensor_velocity = '0;
    forever begin
      @(negedge clock);
      sensor_ack = 1'b0;
      if (!reset_n) begin
        pend = 1'b0;
      end else if (!sensor_req) begin
        pend = 1'b0;
        if (noise_en && $urandom_range(0, 3) == 0) begin
          sensor_ack      = 1'b1;
          sensor_position = $urandom;
          sensor_velocity = $urandom;
        end
      end else begin
        if (!pend || int'(sensor_motor) != cur_m) begin
          pend  = 1'b1;
          cur_m = int'(sensor_motor);
          if (cur_m == 0) mdl_cycles = 0;
          skip = (cur_m == never_ack_motor);
          if (cur_m == delay_motor) wait_left = delay_val;
          else if (rand_delay)      wait_left = $urandom_range(0, 4);
          else                      wait_left = 0;
          d0 = wait_left;
          if (skip) begin
            mdl_tf[cur_m] = 1'b1;
            mdl_cycles += TMO;
            if (cur_m == N - 1) push_sweep();
          end
        end
        if (!skip) begin
          sensor_position = $urandom;
          sensor_velocity = $urandom;
          if (wait_left == 0) begin
            sensor_ack       = 1'b1;
            mdl_duty[cur_m]  = pd_fn(sensor_position, sensor_velocity, 4'(cur_m));
            mdl_cycles      += d0 + 3 + L;
            e.motor   = 4'(cur_m);
            e.pos     = sensor_position;
            e.vel     = sensor_velocity;
            e.ack_cyc = cyc;
            upd_q.push_back(e);
            if (cur_m == N - 1) push_sweep();
            pend = 1'b0;
          end else begin
            wait_left--;
          end
        end
      end
    end
  end

  // Controller stand-in: result is valid only in the cycle CTRL_LATENCY+1 after the strobe.
  initial begin : controller
    int          cd;
    logic [31:0] val;
    cd = 0; val = '0; pd_duty = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        cd = 0;
        pd_duty = '0;
      end else begin
        pd_duty = (cd == 1) ? val : $urandom;
        if (cd > 0) cd--;
        if (pd_update) begin
          val = pd_fn(pd_position, pd_velocity, pd_motor_sel);
          cd  = L + 1;
        end
      end
    end
  end

  initial begin : monitor
    int     busy_run;
    upd_t   u;
    sweep_t s;
    busy_run = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        if (pd_update) begin
          if (upd_q.size() == 0) begin
            check(1'b0, "unexpected_pd_update", 64'(pd_motor_sel), 64'hF);
          end else begin
            u = upd_q.pop_front();
            check(pd_motor_sel == u.motor, "upd_motor", 64'(pd_motor_sel), 64'(u.motor));
            check(pd_position == u.pos, "upd_position", 64'(pd_position), 64'(u.pos));
            check(pd_velocity == u.vel, "upd_velocity", 64'(pd_velocity), 64'(u.vel));
            check(cyc == u.ack_cyc + 1, "upd_latency", 64'(cyc - u.ack_cyc), 64'd1);
          end
        end
        if (sweep_done) begin
          if (sweep_q.size() == 0) begin
            check(1'b0, "unexpected_sweep_done", 64'd1, 64'd0);
          end else begin
            s = sweep_q.pop_front();
            check(busy_run == s.cycles, "sweep_busy_cycles", 64'(busy_run), 64'(s.cycles));
            check(timeout_flags == s.tf, "sweep_timeout_flags", 64'(timeout_flags), 64'(s.tf));
            for (int m = 0; m < N; m++)
              check(duty[m] == s.d[m], $sformatf("duty%0d", m), 64'(duty[m]), 64'(s.d[m]));
          end
          busy_run = 0;
        end
      end
    end
  end

  task automatic wait_done(input int max, input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge clock);
      got = sweep_done;
    end
    if (!got) check(1'b0, name, 64'd0, 64'd1);
  endtask

  task automatic wait_req_motor(input int m, input int max, input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge clock);
      got = sensor_req && (sensor_motor == 4'(m));
    end
    if (!got) check(1'b0, name, 64'd0, 64'd1);
  endtask

  task automatic wait_update_motor(input int m, input int max, input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge clock);
      got = pd_update && (pd_motor_sel == 4'(m));
    end
    if (!got) check(1'b0, name, 64'd0, 64'd1);
  endtask

  // Releases reset and counts clock edges until the first request appears.
  task automatic release_and_measure(input int exp, input string name);
    int k;
    bit got;
    k = 0; got = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    while (!got && k < 3 * exp + 10) begin
      @(posedge clock);
      k++;
      @(negedge clock);
      got = sensor_req;
    end
    check(got && k == exp, name, 64'(k), 64'(exp));
  endtask

  initial begin : main
    longint t_prev;
    int     reqs;
    reset_n = 1'b0; enable = 1'b0; clear_flags = 1'b0; update_period = 32'd100;
    repeat (3) @(negedge clock);
    check(duty == '0, "rst_duty", 64'(duty[0]), 64'd0);
    check(!busy, "rst_busy", 64'(busy), 64'd0);
    check(!sensor_req, "rst_sensor_req", 64'(sensor_req), 64'd0);
    check(!pd_update, "rst_pd_update", 64'(pd_update), 64'd0);
    check(!overrun, "rst_overrun", 64'(overrun), 64'd0);
    check(timeout_flags == '0, "rst_timeout_flags", 64'(timeout_flags), 64'd0);

    // Immediate acks, period 100.
    enable = 1'b1;
    release_and_measure(100, "first_req_latency");
    wait_done(200, "sweep_a0_timeout");
    t_prev = cyc;
    for (int i = 0; i < 2; i++) begin
      wait_done(200, "sweep_a_timeout");
      check(cyc - t_prev == 100, "sweep_spacing", 64'(cyc - t_prev), 64'd100);
      t_prev = cyc;
    end

    // Motor 2 acks three cycles late.
    delay_motor = 2; delay_val = 3;
    wait_done(200, "sweep_b_timeout");
    delay_motor = -1;

    // Random ack delays with stray acks outside requests.
    rand_delay = 1'b1; noise_en = 1'b1; update_period = 32'd200;
    repeat (6) wait_done(400, "sweep_c_timeout");
    rand_delay = 1'b0; noise_en = 1'b0;

    // Motor 5 never acknowledges.
    never_ack_motor = 5; update_period = 32'd400;
    repeat (2) begin
      wait_done(800, "sweep_d_timeout");
      check(timeout_flags == 8'h20, "timeout_flags_0x20", 64'(timeout_flags), 64'h20);
    end
    never_ack_motor = -1; enable = 1'b0;
    @(negedge clock); clear_flags = 1'b1;
    @(negedge clock); clear_flags = 1'b0; mdl_tf = '0;
    check(timeout_flags == '0, "timeout_flags_cleared", 64'(timeout_flags), 64'd0);

    // Period shorter than a sweep.
    check(!overrun, "overrun_before", 64'(overrun), 64'd0);
    update_period = 32'd30; enable = 1'b1;
    wait_done(600, "sweep_e0_timeout");
    check(overrun, "overrun_set", 64'(overrun), 64'd1);
    t_prev = cyc;
    wait_done(200, "sweep_e1_timeout");
    check(cyc - t_prev == 60, "overrun_restart_spacing", 64'(cyc - t_prev), 64'd60);
    enable = 1'b0;
    @(negedge clock); clear_flags = 1'b1;
    @(negedge clock); clear_flags = 1'b0;
    check(!overrun, "overrun_cleared", 64'(overrun), 64'd0);

    // Enable dropped mid-sweep.
    update_period = 32'd100; enable = 1'b1;
    wait_req_motor(4, 400, "req_motor4_timeout");
    enable = 1'b0;
    wait_done(100, "sweep_f_timeout");
    reqs = 0;
    repeat (250) begin
      @(negedge clock);
      if (sensor_req) reqs++;
    end
    check(reqs == 0, "no_req_while_disabled", 64'(reqs), 64'd0);
    enable = 1'b1;
    wait_req_motor(0, 110, "req_after_enable_timeout");

    // Reset during WAIT of motor 3.
    wait_update_motor(3, 100, "update_motor3_timeout");
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check(duty == '0, "reset_mid_duty", 64'(duty[0]), 64'd0);
    check(!busy, "reset_mid_busy", 64'(busy), 64'd0);
    upd_q.delete(); sweep_q.delete(); mdl_duty = '0; mdl_tf = '0;
    release_and_measure(100, "req_after_reset_latency");
    wait_done(200, "sweep_g_timeout");
    enable = 1'b0;
    repeat (5) @(negedge clock);
    check(upd_q.size() == 0, "upd_queue_drained", 64'(upd_q.size()), 64'd0);
    check(sweep_q.size() == 0, "sweep_queue_drained", 64'(sweep_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msj_pd_scheduler.md
# msj_pd_scheduler

Time-multiplexes one shared PD controller datapath across `NUMBER_OF_MOTORS` motors of the MSJ platform. Once per control period it sweeps all motors in order:
- fetches each motor's position and velocity from the sensor interface over a req/ack handshake;
- presents them to the shared controller with a single-cycle update strobe;
- captures the resulting duty into a per-motor duty register.

It sits between the encoder/sensor readers, the single PD controller instance and the PWM generators.

## Interface
Parameters:
- `NUMBER_OF_MOTORS`, 8, motors per sweep (2..16)
- `CTRL_LATENCY`, 2, cycles from update strobe to `pd_duty` valid (>=1)
- `ACK_TIMEOUT`, 255, max cycles waiting for `sensor_ack` before a motor is skipped

Ports:
- `clock`  in  1  system clock; single clock domain
- `reset_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  allows new sweeps to start
- `update_period`  in  32  control period in clock cycles; values <2 treated as 2
- `clear_flags`  in  1  clears `overrun` and `timeout_flags`
- `sensor_req`  out  1  sensor read request
- `sensor_motor`  out  4  motor index of current request
- `sensor_ack`  in  1  sensor data valid, one-cycle pulse
- `sensor_position`  in  32 signed  position of `sensor_motor`
- `sensor_velocity`  in  32 signed  velocity of `sensor_motor`
- `pd_motor_sel`  out  4  motor index, selects gains/setpoint/mode externally
- `pd_position`  out  32 signed  latched position to controller
- `pd_velocity`  out  32 signed  latched velocity to controller
- `pd_update`  out  1  controller update strobe
- `pd_duty`  in  32 signed  controller duty result
- `duty`  out  `NUMBER_OF_MOTORS`x32 signed  per-motor duty registers
- `busy`  out  1  sweep in progress
- `sweep_done`  out  1  one-cycle pulse at end of sweep
- `overrun`  out  1  sticky: period tick arrived during a sweep
- `timeout_flags`  out  `NUMBER_OF_MOTORS`  sticky per-motor ack timeout

## Operation
- Period counter runs continuously, independent of `enable`. It counts 0..`update_period`-1, emits a one-cycle `tick` at the terminal count, then wraps to 0. A new `update_period` takes effect at the next wrap.
- States: IDLE, REQ, UPDATE, WAIT, STORE.
- IDLE:
  - on `tick` with `enable`=1: index=0, go to REQ.
  - on `tick` with `enable`=0: tick ignored.
- REQ:
  - `sensor_req`=1, `sensor_motor`=index.
  - On `sensor_ack`=1: latch `sensor_position`/`sensor_velocity` into `pd_position`/`pd_velocity`, go to UPDATE.
  - Timeout counter increments each cycle in REQ. Reaching `ACK_TIMEOUT` without ack: set `timeout_flags[index]`, leave `duty[index]` unchanged, advance as STORE does (no update strobe).
- UPDATE: `pd_update`=1 for exactly one cycle, then go to WAIT.
- WAIT: `pd_update`=0 for `CTRL_LATENCY` cycles, then go to STORE.
- STORE:
  - `duty[index]` <= `pd_duty`.
  - If index=`NUMBER_OF_MOTORS`-1: pulse `sweep_done`, go to IDLE.
  - Otherwise: index+1, go to REQ.
- `pd_motor_sel`=index. `pd_motor_sel`, `pd_position` and `pd_velocity` are stable from UPDATE through STORE.
- `sensor_ack` outside REQ is ignored.
- `busy`=1 in every state except IDLE.
- Deasserting `enable` mid-sweep lets the current sweep complete; no new sweep starts.
- `tick` while not in IDLE sets `overrun`; that tick is dropped.
- `clear_flags` clears all sticky flags. If a set event and `clear_flags` occur in the same cycle, the set wins.

## Timing
- Reset values (async on `reset_n` low):
  - state IDLE, index 0, counters 0.
  - all outputs 0, including every `duty` entry, `overrun` and `timeout_flags`.
- Reset mid-sweep aborts immediately. The first sweep after release waits for a full period.
- Latency, `tick` to first `sensor_req`: 1 cycle.
- Per motor with immediate ack: REQ 1 + UPDATE 1 + WAIT `CTRL_LATENCY` + STORE 1 cycles. Default 5 cycles; a full sweep of 8 motors takes 40 cycles.
- `pd_update` is always preceded and followed by at least one low cycle, which satisfies the controller's rising-edge detect.
- `duty[index]` updates on the clock edge that ends STORE. `sweep_done` is high in the cycle after the last STORE.
- Timed-out motor: exactly `ACK_TIMEOUT` cycles spent in REQ, then the next motor's REQ follows directly.

## Test plan
- `update_period`=100, `enable`=1, ack in the same cycle as req, `pd_duty`=index*10:
  - `duty`=0,10,..,70 after each sweep;
  - `sweep_done` every 100 cycles;
  - `busy` high for 40 cycles.
- Ack delayed 3 cycles for motor 2: `pd_update` asserted 1 cycle after ack; `pd_position` equals the value sampled at ack; sweep takes 43 cycles.
- Motor 5 never acks, `ACK_TIMEOUT`=255:
  - `timeout_flags`=0x20;
  - `duty[5]` holds its previous value;
  - motors 6..7 still update.
  - `clear_flags` clears the flag.
- `update_period`=30 (shorter than the 40-cycle sweep): `overrun` sets at the first mid-sweep tick; the next sweep starts on the first tick seen in IDLE.
- `reset_n` pulsed low during WAIT of motor 3: all `duty` entries 0, `busy` 0 immediately; the next sweep starts after a full period.
- `enable` dropped during motor 4: sweep completes through motor 7 with `sweep_done`; no further `sensor_req` until `enable` returns and a tick occurs.
